modmul_arbiter: RTL and testbench

Round-robin arbiter that shares one fully pipelined, non-stallable modular multiplier (intmul followed by a reduction stage) among NREQ requesters, such as NTT butterfly lanes and twiddle-update logic. It accepts at most one operand pair per cycle. A LAT-deep valid/ID shadow pipeline routes each product back to the requester that issued it. It also holds the modulus register that drives the multiplier's q input, and allows that register to be reconfigured only while the multiplier pipeline is empty.

---
 rtl/modmul_arbiter.sv | 121 ++++++++++++
 tb/tb_modmul_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_arbiter.sv
// rtl/modmul_arbiter.sv - round-robin front end sharing one pipelined modular multiplier
// Owns the modulus register and routes each product back to its requester by position.
module modmul_arbiter #(
  parameter int LOGQ = 64,
  parameter int NREQ = 4,
  parameter int LAT  = 8,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*LOGQ-1:0] req_a,
  input  logic [NREQ*LOGQ-1:0] req_b,
  output logic [LOGQ-1:0]      mm_a,
  output logic [LOGQ-1:0]      mm_b,
  output logic [LOGQ-1:0]      mm_q,
  input  logic [LOGQ-1:0]      mm_c,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [LOGQ-1:0]      rsp_data,
  input  logic                 cfg_we,
  input  logic [LOGQ-1:0]      cfg_q,
  output logic                 cfg_err,
  output logic                 busy
);

  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [LOGQ-1:0]        mm_a_q, mm_a_d;
  logic [LOGQ-1:0]        mm_b_q, mm_b_d;
  logic [LOGQ-1:0]        mm_q_q, mm_q_d;
  logic [LAT:0]           vld_q, vld_d;
  logic [LAT:0][IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]         rsp_id_q, rsp_id_d;
  logic [LOGQ-1:0]        rsp_data_q, rsp_data_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   found;
  logic                   xfer;
  logic [IDW-1:0]         gnt_id;

  // Grant search starts at the pointer; a pending config write suppresses issue.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[(int'(ptr_q) + i) % NREQ]) begin
        found  = 1'b1;
        gnt_id = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
    xfer      = found && !cfg_we && !rst;
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  assign busy = (|vld_q) | (|rsp_valid_q);

  always_comb begin
    ptr_d       = ptr_q;
    mm_a_d      = mm_a_q;
    mm_b_d      = mm_b_q;
    mm_q_d      = mm_q_q;
    cfg_err_d   = 1'b0;
    rsp_valid_d = '0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (xfer) begin
      ptr_d  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      mm_a_d = req_a[int'(gnt_id) * LOGQ +: LOGQ];
      mm_b_d = req_b[int'(gnt_id) * LOGQ +: LOGQ];
    end
    if (cfg_we) begin
      if (busy || xfer) cfg_err_d = 1'b1;
      else              mm_q_d    = cfg_q;
    end
    // Stage 0 is aligned with mm_a/mm_b, stage LAT with mm_c.
    vld_d = {vld_q[LAT-1:0], xfer};
    id_d  = {id_q[LAT-1:0], gnt_id};
    if (vld_q[LAT]) begin
      rsp_valid_d[id_q[LAT]] = 1'b1;
      rsp_id_d               = id_q[LAT];
      rsp_data_d             = mm_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      mm_q_q      <= '0;
      vld_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      mm_a_q      <= mm_a_d;
      mm_b_q      <= mm_b_d;
      mm_q_q      <= mm_q_d;
      vld_q       <= vld_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign mm_q      = mm_q_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_modmul_arbiter.sv
// tb/tb_modmul_arbiter.sv - directed bench for modmul_arbiter with a 4-cycle a*b mod q stub
module tb_modmul_arbiter;
  localparam int LOGQ = 16;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*LOGQ-1:0] req_a;
  logic [NREQ*LOGQ-1:0] req_b;
  logic [LOGQ-1:0]      mm_a, mm_b, mm_q, mm_c;
  logic [NREQ-1:0]      rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [LOGQ-1:0]      rsp_data;
  logic                 cfg_we;
  logic [LOGQ-1:0]      cfg_q;
  logic                 cfg_err;
  logic                 busy;

  modmul_arbiter #(.LOGQ(LOGQ), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mm_a(mm_a), .mm_b(mm_b), .mm_q(mm_q), .mm_c(mm_c),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .cfg_we(cfg_we), .cfg_q(cfg_q), .cfg_err(cfg_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stub multiplier: LAT registers between mm_a/mm_b and mm_c.
  bit [LOGQ-1:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    pipe[0] <= (mm_q == '0) ? '0 : LOGQ'((32'(mm_a) * 32'(mm_b)) % 32'(mm_q));
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mm_c = pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_v[$];
  int q_id[$];
  int q_data[$];
  int q_cyc[$];
  int rsp_cnt = 0;
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      q_v.push_back(int'(rsp_valid));
      q_id.push_back(int'(rsp_id));
      q_data.push_back(int'(rsp_data));
      q_cyc.push_back(cyc);
      rsp_cnt <= rsp_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*LOGQ +: LOGQ] = LOGQ'(a);
    req_b[i*LOGQ +: LOGQ] = LOGQ'(b);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && busy; n++) tick();
    chk("idle", 64'(busy), 64'd0);
  endtask

  int base;
  int cnt_base;
  int seen;

  initial begin
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; cfg_we = 1'b0; cfg_q = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mmq", 64'(mm_q), 64'd0);
    chk("rst_rspv", 64'(rsp_valid), 64'd0);
    chk("rst_cfgerr", 64'(cfg_err), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Modulus 17 then a single request from requester 2: 5*7 mod 17 = 1.
    cfg_we = 1'b1; cfg_q = 16'd17;
    tick();
    cfg_we = 1'b0;
    chk("cfg17_mmq", 64'(mm_q), 64'd17);
    chk("cfg17_err", 64'(cfg_err), 64'd0);
    for (int i = 0; i < NREQ; i++) set_op(i, i + 2, 3);
    set_op(2, 5, 7);
    req_valid = 4'b0100;
    #1 chk("single_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk("single_mma", 64'(mm_a), 64'd5);
    chk("single_busy", 64'(busy), 64'd1);
    repeat (4) tick();
    chk("single_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("single_rspv", 64'(rsp_valid), 64'b0100);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_data", 64'(rsp_data), 64'd1);
    chk("single_busy_hold", 64'(busy), 64'd1);
    tick();
    chk("single_rspv_drop", 64'(rsp_valid), 64'd0);
    chk("single_busy_fall", 64'(busy), 64'd0);
    chk("single_data_hold", 64'(rsp_data), 64'd1);

    // Lone requester 3 moves the pointer to 0.
    set_op(2, 4, 3);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_idle();

    // Round robin with all four valid: grants 0,1,2,3,0,1,2,3.
    base = q_id.size();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(1 << (k % 4)));
      tick();
    end
    req_valid = '0;
    wait_idle();
    chk("rr_count", 64'(q_id.size() - base), 64'd8);
    if (q_id.size() - base == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("rr_v%0d", k), 64'(q_v[base+k]), 64'(1 << (k % 4)));
        chk($sformatf("rr_id%0d", k), 64'(q_id[base+k]), 64'(k % 4));
        chk($sformatf("rr_data%0d", k), 64'(q_data[base+k]), 64'((((k % 4) + 2) * 3) % 17));
        chk($sformatf("rr_cyc%0d", k), 64'(q_cyc[base+k] - q_cyc[base]), 64'(k));
      end
    end

    // Fairness: 1 and 3 alternate, then requester 0 joins.
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("fair_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'b0010 : 64'b1000);
      tick();
    end
    req_valid = 4'b1011;
    seen = 0;
    for (int k = 0; k < NREQ; k++) begin
      #1 if (req_ready[0]) seen = 1;
      tick();
    end
    chk("fair_r0_granted", 64'(seen), 64'd1);
    req_valid = '0;
    wait_idle();

    // Config lockout while busy, then retry once idle.
    set_op(0, 10, 10);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    cfg_we = 1'b1; cfg_q = 16'd97;
    tick();
    cfg_we = 1'b0;
    chk("lock_err", 64'(cfg_err), 64'd1);
    chk("lock_mmq", 64'(mm_q), 64'd17);
    tick();
    chk("lock_err_pulse", 64'(cfg_err), 64'd0);
    wait_idle();
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("retry_mmq", 64'(mm_q), 64'd97);
    chk("retry_err", 64'(cfg_err), 64'd0);
    base = q_id.size();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_idle();
    chk("q97_count", 64'(q_id.size() - base), 64'd1);
    if (q_id.size() - base == 1) begin
      chk("q97_id", 64'(q_id[base]), 64'd0);
      chk("q97_data", 64'(q_data[base]), 64'd3);
    end

    // cfg_we blocks issue for one cycle; pointer sits at 1.
    cfg_we = 1'b1; req_valid = 4'b1111;
    #1 chk("cfgblk_ready", 64'(req_ready), 64'd0);
    tick();
    cfg_we = 1'b0;
    chk("cfgblk_busy", 64'(busy), 64'd0);
    chk("cfgblk_mma", 64'(mm_a), 64'd10);
    #1 chk("cfgblk_resume", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk("cfgblk_mma_next", 64'(mm_a), 64'd3);
    wait_idle();

    // Asynchronous reset with operations in flight.
    cnt_base = rsp_cnt;
    req_valid = 4'b0111;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_rspv", 64'(rsp_valid), 64'd0);
    chk("arst_id", 64'(rsp_id), 64'd0);
    chk("arst_data", 64'(rsp_data), 64'd0);
    chk("arst_mma", 64'(mm_a), 64'd0);
    chk("arst_mmb", 64'(mm_b), 64'd0);
    chk("arst_mmq", 64'(mm_q), 64'd0);
    chk("arst_err", 64'(cfg_err), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    req_valid = '0;
    rst = 1'b0;
    repeat (12) tick();
    chk("arst_no_rsp", 64'(rsp_cnt - cnt_base), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
